instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set fetch-address and PC width.
REQ-002 Parameter DATA_W, default 16, SHALL set instruction width.
REQ-003 Parameter DEPTH, default 4, SHALL set prefetch FIFO entries (power of 2, >=2).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 rst  input  1  SHALL be synchronous, active-high reset.
REQ-006 redirect  input  1  SHALL request a fetch restart at redirect_pc.
REQ-007 redirect_pc  input  ADDR_W  SHALL carry the new fetch address.
REQ-008 mem_req  output  1  SHALL request an instruction-memory read.
REQ-009 mem_addr  output  ADDR_W  SHALL carry the word address of the request.
REQ-010 mem_gnt  input  1  SHALL accept the request when high with mem_req.
REQ-011 mem_rvalid  input  1  SHALL mark a read response, in order, >=1 cycle after gnt.
REQ-012 mem_rdata  input  DATA_W  SHALL carry response data.
REQ-013 instr_valid  output  1  SHALL flag FIFO head valid.
REQ-014 instr  output  DATA_W  SHALL be FIFO head instruction.
REQ-015 instr_pc  output  ADDR_W  SHALL be FIFO head address.
REQ-016 instr_ready  input  1  SHALL pop head when high with instr_valid.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-018 IDLE: mem_req=0; go REQ when FIFO count < DEPTH.
REQ-019 REQ: mem_req=1, mem_addr=fetch_pc held stable until mem_gnt; on gnt latch req_pc=fetch_pc, fetch_pc+=1 (mod 2^ADDR_W, 0xFFFF->0x0000), go WAIT.
REQ-020 WAIT: mem_req=0; on mem_rvalid push {req_pc, mem_rdata}; go REQ if post-push count < DEPTH, else IDLE.
REQ-021 Push and pop in same cycle SHALL both occur; count unchanged; full FIFO with pop still accepts push.
REQ-022 FSM SHALL enter REQ only when a free slot exists for the response (count < DEPTH).
REQ-023 mem_rvalid in IDLE or REQ SHALL be ignored.
REQ-024 instr/instr_pc SHALL reflect FIFO head combinationally from storage; undefined contents gated by instr_valid=0.
REQ-025 redirect SHALL have priority over all other events: FIFO flushed (count=0, instr_valid=0 next cycle), fetch_pc=redirect_pc.
REQ-026 redirect in REQ without gnt: stay REQ, mem_addr=redirect_pc next cycle (only permitted mem_addr change while mem_req=1).
REQ-027 redirect in REQ with gnt same cycle: go DROP (granted response discarded).
REQ-028 redirect in WAIT without rvalid: go DROP; with rvalid same cycle: response discarded, go REQ.
REQ-029 DROP: mem_req=0; next mem_rvalid discarded, go REQ; redirect in DROP updates fetch_pc, stays DROP.
REQ-030 redirect in IDLE: go REQ.
REQ-031 Pop on the redirect cycle SHALL be ignored (flush wins).
REQ-032 Latency: first instr_valid SHALL assert 1 cycle after the rvalid of its response.

Reset
REQ-033 rst SHALL set state=REQ, fetch_pc=0, FIFO count=0, pointers=0 on next edge; mem_req asserts from first cycle after rst deasserts.
REQ-034 During rst high: mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0.
REQ-035 rst mid-operation SHALL abandon any outstanding request; late mem_rvalid then falls in REQ and is ignored per REQ-023.

Verification
REQ-036 Reset, gnt immediate, rvalid 1 cycle later, rdata=0x1000+addr, instr_ready=1 -> instr/instr_pc stream (0x1000,0x0000),(0x1001,0x0001),... in order, no gaps beyond protocol.
REQ-037 instr_ready=0, memory always responsive -> exactly 4 pushes, FSM IDLE, mem_req=0, addresses 0..3; ready=1 for one cycle -> one pop, one new request for 0x0004.
REQ-038 redirect_pc=0x00A0 while WAIT -> next rvalid discarded, next mem_addr=0x00A0, first instr_pc=0x00A0, no stale entry visible.
REQ-039 redirect_pc=0xFFFF -> instr_pc sequence 0xFFFF, 0x0000, 0x0001.
REQ-040 rst asserted in WAIT, rvalid arrives cycle after rst deasserts -> ignored; first delivered instr_pc=0x0000 with data of new response.
REQ-041 redirect and mem_gnt same cycle in REQ -> DROP; granted response never appears on instr.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction prefetch unit with one outstanding memory read and a PC-tagged FIFO
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     post_push;
  logic              push;
  logic              pop;
  logic              granted;

  // A flush on the redirect cycle wins over a consumer pop.
  assign pop       = instr_valid && instr_ready && !redirect;
  assign granted   = (state == REQ) && mem_gnt;
  assign post_push = count + CW'(1) - CW'(pop);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect || count < FULL) state_nxt = REQ;
      end
      REQ: begin
        if (mem_gnt) state_nxt = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          push = !redirect;
          if (redirect || post_push < FULL) state_nxt = REQ;
          else                              state_nxt = IDLE;
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        // The discarded response retires the outstanding read even if a redirect lands with it.
        if (mem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      fetch_pc <= '0;
      req_pc   <= '0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      state <= state_nxt;
      if (granted) req_pc <= fetch_pc;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        count    <= '0;
        wptr     <= '0;
        rptr     <= '0;
      end else begin
        if (granted) fetch_pc <= fetch_pc + ADDR_W'(1);
        if (push)    wptr     <= wptr + PW'(1);
        if (pop)     rptr     <= rptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      data_mem[wptr] <= mem_rdata;
      pc_mem[wptr]   <= req_pc;
    end
  end

  assign mem_req     = !rst && (state == REQ);
  assign mem_addr    = rst ? '0 : fetch_pc;
  assign instr_valid = !rst && (count != '0);
  assign instr       = instr_valid ? data_mem[rptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rptr]   : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized bench for instr_fetch against a queue-based fetch-stream model
module tb_instr_fetch;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } entry_t;

  int checks = 0;
  int errors = 0;

  // memory model: at most one read in flight
  bit            pend = 0;
  bit            pend_stale = 0;
  int            pend_lat = 0;
  logic [AW-1:0] pend_pc = '0;
  int            gnt_pct = 100;
  int            lat_min = 0;
  int            lat_max = 0;
  int            ready_pct = 100;
  bit            data_rand = 0;

  // reference: instructions not yet consumed, and the next address the fetcher must request
  entry_t        q[$];
  logic [AW-1:0] exp_fetch = '0;

  bit            last_hold = 0;
  bit            last_redir = 0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] last_redir_pc = '0;

  logic [AW-1:0] popped_pc[$];
  logic [DW-1:0] popped_data[$];
  logic [AW-1:0] gnt_addrs[$];

  task automatic clear_stats();
    popped_pc.delete();
    popped_data.delete();
    gnt_addrs.delete();
  endtask

  // One clock: drive memory/consumer at negedge, compare, advance the model across the edge.
  task automatic cycle();
    bit            arrive;
    bit            push_ok;
    bit            popping;
    entry_t        e;
    logic [DW-1:0] d;
    arrive = 0; push_ok = 0; e = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend) begin
      if (pend_lat == 0) begin
        d = data_rand ? DW'($urandom) : (16'h1000 + pend_pc);
        arrive = 1; push_ok = !pend_stale; pend = 0;
        mem_rvalid = 1'b1; mem_rdata = d;
        e.pc = pend_pc; e.data = d;
      end else begin
        pend_lat--;
      end
    end
    instr_ready = ($urandom_range(0, 99) < ready_pct);
    #1;
    mem_gnt = mem_req && ($urandom_range(0, 99) < gnt_pct);

    if (!rst) begin
      checks++;
      if (instr_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL instr_valid t=%0t: got %b want %b", $time, instr_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (instr_pc !== q[0].pc || instr !== q[0].data) begin
          errors++;
          $display("FAIL fifo_head t=%0t: got pc=%h data=%h want pc=%h data=%h",
                   $time, instr_pc, instr, q[0].pc, q[0].data);
        end
      end
      if (last_hold) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== (last_redir ? last_redir_pc : last_addr)) begin
          errors++;
          $display("FAIL req_hold t=%0t: got req=%b addr=%h want req=1 addr=%h",
                   $time, mem_req, mem_addr, last_redir ? last_redir_pc : last_addr);
        end
      end
    end

    if (mem_gnt) begin
      checks++;
      if (mem_addr !== exp_fetch || pend) begin
        errors++;
        $display("FAIL grant t=%0t: got addr=%h outstanding=%0d want addr=%h outstanding=0",
                 $time, mem_addr, pend, exp_fetch);
      end
      pend = 1; pend_stale = 0; pend_pc = exp_fetch;
      pend_lat = $urandom_range(lat_min, lat_max);
      gnt_addrs.push_back(exp_fetch);
      exp_fetch++;
    end

    popping = (q.size() != 0) && instr_ready && !redirect && !rst;
    if (popping) begin
      popped_pc.push_back(q[0].pc);
      popped_data.push_back(q[0].data);
      void'(q.pop_front());
    end
    if (arrive && push_ok && !redirect && !rst) begin
      q.push_back(e);
      checks++;
      if (q.size() > DEPTH) begin
        errors++;
        $display("FAIL overfill t=%0t: got %0d entries want <= %0d", $time, q.size(), DEPTH);
      end
    end
    if (rst || redirect) begin
      q.delete();
      exp_fetch = rst ? '0 : redirect_pc;
      if (pend) pend_stale = 1;
    end

    last_hold     = !rst && mem_req && !mem_gnt;
    last_redir    = redirect;
    last_redir_pc = redirect_pc;
    last_addr     = mem_addr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; pend = 0; gnt_pct = 0;
    cycle(); cycle();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; pend = 0;
    gnt_pct = 100; ready_pct = 100;
    cycle(); cycle();
    #1;
    checks++;
    if ({mem_req, mem_addr, instr_valid, instr, instr_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b instr=%h pc=%h want all 0",
               mem_req, mem_addr, instr_valid, instr, instr_pc);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== '0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got req=%b addr=%h v=%b want req=1 addr=0000 v=0",
               mem_req, mem_addr, instr_valid);
    end
    mem_gnt = 1'b0;
    last_hold = 0;
    @(negedge clk);
    clear_stats();
  endtask

  task automatic test_stream();
    int bad;
    do_reset();
    data_rand = 0; gnt_pct = 100; lat_min = 0; lat_max = 0; ready_pct = 100;
    repeat (40) cycle();
    checks++;
    if (popped_pc.size() < 18) begin
      errors++;
      $display("FAIL stream_rate: got %0d instrs want >= 18", popped_pc.size());
    end
    bad = 0;
    foreach (popped_pc[i])
      if (popped_pc[i] !== AW'(i) || popped_data[i] !== (16'h1000 + AW'(i))) bad++;
    checks++;
    if (bad != 0 || popped_pc.size() == 0) begin
      errors++;
      $display("FAIL stream_order: got %0d bad of %0d want 0 bad", bad, popped_pc.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    data_rand = 1; gnt_pct = 100; lat_min = 0; lat_max = 2; ready_pct = 0;
    repeat (40) cycle();
    checks++;
    if (gnt_addrs.size() != DEPTH || mem_req !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_fill: got grants=%0d req=%b v=%b want grants=%0d req=0 v=1",
               gnt_addrs.size(), mem_req, instr_valid, DEPTH);
    end
    checks++;
    if (gnt_addrs.size() < DEPTH || gnt_addrs[DEPTH-1] !== AW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL bp_last_addr: got %0d grants want last addr %0d", gnt_addrs.size(), DEPTH - 1);
    end
    ready_pct = 100; cycle(); ready_pct = 0;
    repeat (20) cycle();
    checks++;
    if (popped_pc.size() != 1 || gnt_addrs.size() != DEPTH + 1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_one_pop: got pops=%0d grants=%0d req=%b want pops=1 grants=%0d req=0",
               popped_pc.size(), gnt_addrs.size(), mem_req, DEPTH + 1);
    end else begin
      checks++;
      if (popped_pc[0] !== 16'h0000 || gnt_addrs[DEPTH] !== 16'h0004) begin
        errors++;
        $display("FAIL bp_refetch: got pop pc=%h new addr=%h want 0000 0004", popped_pc[0], gnt_addrs[DEPTH]);
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    data_rand = 1; gnt_pct = 100; lat_min = 2; lat_max = 2; ready_pct = 100;
    cycle();
    redirect = 1'b1; redirect_pc = 16'h00A0;
    cycle();
    redirect = 1'b0;
    clear_stats();
    repeat (20) cycle();
    checks++;
    if (gnt_addrs.size() == 0 || popped_pc.size() == 0) begin
      errors++;
      $display("FAIL redir_wait_progress: got grants=%0d pops=%0d want both > 0", gnt_addrs.size(), popped_pc.size());
    end else begin
      checks++;
      if (gnt_addrs[0] !== 16'h00A0 || popped_pc[0] !== 16'h00A0) begin
        errors++;
        $display("FAIL redir_wait: got addr=%h pc=%h want 00a0 00a0", gnt_addrs[0], popped_pc[0]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    data_rand = 1; gnt_pct = 0; lat_min = 0; lat_max = 3; ready_pct = 70;
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    cycle();
    redirect = 1'b0; gnt_pct = 100;
    for (int i = 0; i < 200 && popped_pc.size() < 3; i++) cycle();
    checks++;
    if (popped_pc.size() < 3) begin
      errors++;
      $display("FAIL wrap_timeout: got %0d instrs want 3", popped_pc.size());
    end else begin
      checks++;
      if (popped_pc[0] !== 16'hFFFF || popped_pc[1] !== 16'h0000 || popped_pc[2] !== 16'h0001) begin
        errors++;
        $display("FAIL wrap_seq: got %h %h %h want ffff 0000 0001", popped_pc[0], popped_pc[1], popped_pc[2]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    data_rand = 1; gnt_pct = 100; lat_min = 1; lat_max = 1; ready_pct = 100;
    cycle();
    rst = 1'b1; gnt_pct = 0;
    cycle();
    rst = 1'b0;
    clear_stats();
    cycle();
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL late_rvalid: got v=%b req=%b want v=0 req=1", instr_valid, mem_req);
    end
    gnt_pct = 100;
    for (int i = 0; i < 50 && popped_pc.size() < 1; i++) cycle();
    checks++;
    if (popped_pc.size() < 1 || popped_pc[0] !== 16'h0000) begin
      errors++;
      $display("FAIL rst_wait_first: got %0d instrs first pc=%h want pc 0000",
               popped_pc.size(), popped_pc.size() ? popped_pc[0] : 16'hxxxx);
    end
  endtask

  task automatic test_redirect_gnt();
    do_reset();
    data_rand = 1; gnt_pct = 100; lat_min = 1; lat_max = 1; ready_pct = 100;
    redirect = 1'b1; redirect_pc = 16'h0300;
    cycle();
    redirect = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_req: got req=%b want 0", mem_req);
    end
    for (int i = 0; i < 50 && popped_pc.size() < 2; i++) cycle();
    checks++;
    if (popped_pc.size() < 2 || gnt_addrs.size() < 2) begin
      errors++;
      $display("FAIL drop_timeout: got pops=%0d grants=%0d want >= 2", popped_pc.size(), gnt_addrs.size());
    end else begin
      checks++;
      if (gnt_addrs[0] !== 16'h0000 || gnt_addrs[1] !== 16'h0300 ||
          popped_pc[0] !== 16'h0300 || popped_pc[1] !== 16'h0301) begin
        errors++;
        $display("FAIL drop_seq: got grants %h %h pcs %h %h want 0000 0300 / 0300 0301",
                 gnt_addrs[0], gnt_addrs[1], popped_pc[0], popped_pc[1]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    data_rand = 1; gnt_pct = 60; lat_min = 0; lat_max = 3; ready_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      redirect    = ($urandom_range(0, 99) < 4);
      redirect_pc = AW'($urandom);
      cycle();
    end
    redirect = 1'b0;
    checks++;
    if (popped_pc.size() < 100) begin
      errors++;
      $display("FAIL random_progress: got %0d instrs want >= 100", popped_pc.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_wrap();
    test_reset_in_wait();
    test_redirect_gnt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
